param_serial_demux: RTL and testbench
=====================================

// Module: param_serial_demux
// PURPOSE
//   Parametrised serial-frame demultiplexer; next generation of the fixed 4-port serial collector.
//   Frame on se_in: start bit, port address, length field, payload bits, even-parity bit.
//   Payload bits are forwarded, registered, to one of NUM_PORTS serial outputs.
//   Adds a length field, a parity check and a frame-done strobe. Sits between the serial line and per-port consumers.
// PARAMETERS
//   PORT_BITS  2  width of address field; NUM_PORTS = 2**PORT_BITS (localparam)
//   LEN_BITS   4  width of length field; payload length 0 .. 2**LEN_BITS-1 bits
// PORTS
//   clock        in   1          single clock, all logic on rising edge
//   rst          in   1          synchronous, active-high reset
//   se_in        in   1          serial line, idles high, sampled every rising edge
//   valid        out  1          high while a payload bit is presented on serial_out
//   serial_out   out  NUM_PORTS  one-hot-gated payload bit; only bit [port_number] may be 1
//   port_number  out  PORT_BITS  address of current/last frame, held until next address complete
//   done         out  1          1-cycle pulse when the parity bit has been sampled
//   parity_err   out  1          1-cycle pulse coincident with done if parity mismatch
// BEHAVIOUR
//   Reset: state=IDLE; valid, serial_out, port_number, done, parity_err all 0; counters/shift regs 0.
//   Reset mid-frame aborts the frame; no done/parity_err is produced for it.
//   States and transitions, one se_in bit per cycle:
//     IDLE : se_in==0 (start bit) -> ADDR; se_in==1 stay.
//     ADDR : shift in PORT_BITS bits, MSB first; after last bit latch port_number -> LEN.
//     LEN  : shift in LEN_BITS bits, MSB first; after last bit len==0 -> PAR, else -> DATA.
//     DATA : consume exactly len bits; after last bit -> PAR.
//     PAR  : sample parity bit -> IDLE; done=1 next cycle; parity_err=1 if (^payload ^ par)!=0.
//   Forwarding latency is 1 cycle: a payload bit sampled at edge k is visible after edge k+1.
//     At that point valid=1 and serial_out[port_number]=bit, with all other serial_out bits 0.
//   Outside payload cycles valid=0 and serial_out=0.
//   port_number updates on the cycle after the last address bit.
//     It stays stable through the entire DATA phase of that frame.
//   Parity is the XOR running over payload bits only, even parity. len==0 gives expected parity bit 0.
//   Back-to-back frames: IDLE is re-entered after PAR.
//     A 0 on the very next sample is a new start bit.
//     Minimum frame = 1+PORT_BITS+LEN_BITS+1 cycles.
//   done/parity_err pulses may overlap the ADDR phase of a following frame; they are independent.
//   Length counter width = LEN_BITS; no wrap, since the count terminates at len.
//   Address counter width = clog2(PORT_BITS+1).
// STRUCTURE
//   Package param_serial_demux_pkg holds:
//     state_t enum {IDLE, ADDR, LEN, DATA, PAR};
//     the default PORT_BITS/LEN_BITS constants;
//     a clog2 helper function.
//   One sub-module, serial_field_capture #(W):
//     enable-gated MSB-first shift register plus bit counter;
//     outputs value[W-1:0] and last (1-cycle, on Wth bit).
//   Two instances, address and length. The FSM, payload forwarding and parity live in the top.
// TESTING  (PORT_BITS=2, LEN_BITS=4 unless stated)
//   1. Reset then idle with se_in=1 for 20 cycles -> all outputs 0, no done.
//   2. Frame 0|10|0011|101|0 -> port_number=2, then 3 cycles valid=1 with serial_out=4'b0100,0000,0100.
//        done=1 and parity_err=0 one cycle after the parity sample.
//   3. Same frame with parity bit 1 -> done=1 and parity_err=1 in the same cycle.
//   4. Frame 0|01|0000|0 (len 0) -> valid never 1, done=1, parity_err=0, port_number=1.
//   5. Two frames back-to-back to ports 3 then 0, no idle gap -> both fully forwarded.
//        Second port_number changes only after its address bits are complete.
//   6. Assert rst during the DATA phase of a frame to port 1 -> next cycle valid=0 and serial_out=0.
//        No done is produced; a subsequent clean frame is received correctly.
//   Also: PORT_BITS=3, LEN_BITS=5 run of scenario 2 addressed to port 7 -> serial_out[7] only.

Source files
------------

// File: rtl/param_serial_demux_pkg.sv
// Shared types and constants for the parametrised serial-frame demultiplexer.
package param_serial_demux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    PAR
  } state_t;

  localparam int DEFAULT_PORT_BITS = 2;
  localparam int DEFAULT_LEN_BITS  = 4;

  // Bits needed to hold values 0 .. value-1, never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/param_serial_demux_capture.sv
// MSB-first serial field capture: shifts one bit per enabled cycle and flags
// the cycle in which the Wth bit arrives. value already includes the bit
// being presented, so the owner can latch the whole field on that same edge.
module serial_field_capture
  import param_serial_demux_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] value,
  output logic         last
);

  localparam int CW = clog2(W + 1);

  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;

  assign value = (shreg << 1) | W'(bit_in);
  assign last  = en && (cnt == CW'(W - 1));

  // Shift the incoming bit in and count bits, restarting after the Wth bit.
  always_ff @(posedge clock) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (en) begin
      shreg <= value;
      cnt   <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/param_serial_demux.sv
// Serial frame demultiplexer: start bit, port address, length, payload and an
// even-parity bit. Payload bits are forwarded, registered, to the addressed
// serial output; a done strobe (with parity_err) closes every complete frame.
module param_serial_demux
  import param_serial_demux_pkg::*;
#(
  parameter int PORT_BITS = DEFAULT_PORT_BITS,
  parameter int LEN_BITS  = DEFAULT_LEN_BITS,
  localparam int NUM_PORTS = 2 ** PORT_BITS
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 se_in,
  output logic                 valid,
  output logic [NUM_PORTS-1:0] serial_out,
  output logic [PORT_BITS-1:0] port_number,
  output logic                 done,
  output logic                 parity_err
);

  state_t              state;
  logic [LEN_BITS-1:0] len_reg;
  logic [LEN_BITS-1:0] data_cnt;
  logic                parity;

  logic                 addr_en;
  logic                 addr_last;
  logic [PORT_BITS-1:0] addr_value;
  logic                 len_en;
  logic                 len_last;
  logic [LEN_BITS-1:0]  len_value;

  assign addr_en = (state == ADDR);
  assign len_en  = (state == LEN);

  serial_field_capture #(.W(PORT_BITS)) u_addr_capture (
    .clock  (clock),
    .rst    (rst),
    .en     (addr_en),
    .bit_in (se_in),
    .value  (addr_value),
    .last   (addr_last)
  );

  serial_field_capture #(.W(LEN_BITS)) u_len_capture (
    .clock  (clock),
    .rst    (rst),
    .en     (len_en),
    .bit_in (se_in),
    .value  (len_value),
    .last   (len_last)
  );

  // Frame FSM with registered outputs; strobes and forwarded bits default low each cycle.
  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= 1'b0;
      serial_out  <= '0;
      port_number <= '0;
      done        <= 1'b0;
      parity_err  <= 1'b0;
      len_reg     <= '0;
      data_cnt    <= '0;
      parity      <= 1'b0;
    end else begin
      valid      <= 1'b0;
      serial_out <= '0;
      done       <= 1'b0;
      parity_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!se_in) state <= ADDR;
        end
        ADDR: begin
          if (addr_last) begin
            port_number <= addr_value;
            state       <= LEN;
          end
        end
        LEN: begin
          if (len_last) begin
            len_reg  <= len_value;
            data_cnt <= '0;
            parity   <= 1'b0;
            state    <= (len_value == '0) ? PAR : DATA;
          end
        end
        DATA: begin
          valid      <= 1'b1;
          serial_out <= NUM_PORTS'(se_in) << port_number;
          parity     <= parity ^ se_in;
          data_cnt   <= data_cnt + LEN_BITS'(1);
          if (data_cnt == len_reg - LEN_BITS'(1)) state <= PAR;
        end
        PAR: begin
          done       <= 1'b1;
          parity_err <= parity ^ se_in;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_serial_demux.sv
// Scoreboard bench for param_serial_demux: the driver pushes expected payload
// bits and frame results, a negedge monitor pops and compares them.
module tb_param_serial_demux;

  localparam int PB  = 2;
  localparam int LB  = 4;
  localparam int NP  = 2 ** PB;
  localparam int PB2 = 3;
  localparam int LB2 = 5;
  localparam int NP2 = 2 ** PB2;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic          se_in = 1'b1;
  logic          valid;
  logic [NP-1:0] serial_out;
  logic [PB-1:0] port_number;
  logic          done;
  logic          parity_err;

  logic           se_in2 = 1'b1;
  logic           valid2;
  logic [NP2-1:0] serial_out2;
  logic [PB2-1:0] port_number2;
  logic           done2;
  logic           parity_err2;

  typedef struct packed {
    logic [PB-1:0] port;
    logic          b;
  } exp_bit_t;

  exp_bit_t data_q[$];
  bit       done_q[$];

  int tests    = 0;
  int failures = 0;
  int prev_port = 0;

  always #5 clock = ~clock;

  param_serial_demux #(.PORT_BITS(PB), .LEN_BITS(LB)) dut (
    .clock       (clock),
    .rst         (rst),
    .se_in       (se_in),
    .valid       (valid),
    .serial_out  (serial_out),
    .port_number (port_number),
    .done        (done),
    .parity_err  (parity_err)
  );

  param_serial_demux #(.PORT_BITS(PB2), .LEN_BITS(LB2)) dut_wide (
    .clock       (clock),
    .rst         (rst),
    .se_in       (se_in2),
    .valid       (valid2),
    .serial_out  (serial_out2),
    .port_number (port_number2),
    .done        (done2),
    .parity_err  (parity_err2)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic b);
    se_in = b;
    @(posedge clock);
    #1;
  endtask

  // Expected behaviour of one frame: every payload bit appears on the
  // addressed port in order, and parity_err equals whether the sent parity
  // bit was deliberately wrong. abort_at >= 0 asserts rst on that payload bit.
  task automatic send_frame(input int port, input int len, input logic [31:0] payload,
                            input bit flip, input int abort_at);
    bit       par;
    exp_bit_t item;
    par = 1'b0;
    for (int i = 0; i < len; i++) begin
      par = par ^ payload[i];
      if (abort_at < 0 || i < abort_at) begin
        item.port = PB'(port);
        item.b    = payload[i];
        data_q.push_back(item);
      end
    end
    if (abort_at < 0) done_q.push_back(flip);

    apply_stimulus(1'b0);
    for (int i = PB - 1; i >= 0; i--) begin
      apply_stimulus(port[i]);
      if (i > 0) check_output("port_hold", 32'(port_number), 32'(prev_port));
      else       check_output("port_latch", 32'(port_number), 32'(port));
    end
    prev_port = port;
    for (int i = LB - 1; i >= 0; i--) apply_stimulus(len[i]);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        rst   = 1'b1;
        se_in = payload[i];
        @(posedge clock);
        #1;
        rst   = 1'b0;
        se_in = 1'b1;
        check_output("reset_valid", 32'(valid), 32'(0));
        check_output("reset_serial_out", 32'(serial_out), 32'(0));
        check_output("reset_done", 32'(done), 32'(0));
        check_output("reset_port", 32'(port_number), 32'(0));
        prev_port = 0;
        return;
      end
      apply_stimulus(payload[i]);
    end
    apply_stimulus(par ^ flip);
  endtask

  // Monitor: pops the scoreboard on every valid/done and checks idle outputs stay quiet.
  always @(negedge clock) begin
    exp_bit_t exp_item;
    if (valid) begin
      if (data_q.size() == 0) begin
        check_output("unexpected_valid", 32'(serial_out), 32'(0));
        check_output("unexpected_valid_flag", 32'(valid), 32'(0));
      end else begin
        exp_item = data_q.pop_front();
        check_output("fwd_port", 32'(port_number), 32'(exp_item.port));
        check_output("fwd_serial_out", 32'(serial_out), 32'(NP'(exp_item.b) << exp_item.port));
      end
    end else begin
      check_output("idle_serial_out", 32'(serial_out), 32'(0));
    end
    if (done) begin
      if (done_q.size() == 0) check_output("unexpected_done", 32'(done), 32'(0));
      else check_output("parity_err", 32'(parity_err), 32'(done_q.pop_front()));
    end else begin
      check_output("stray_parity_err", 32'(parity_err), 32'(0));
    end
  end

  initial begin
    logic [12:0] wide_frame;
    int          len;
    int          gap;

    rst   = 1'b1;
    se_in = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    check_output("rst_valid", 32'(valid), 32'(0));
    check_output("rst_serial_out", 32'(serial_out), 32'(0));
    check_output("rst_port", 32'(port_number), 32'(0));
    check_output("rst_done", 32'(done), 32'(0));
    check_output("rst_parity_err", 32'(parity_err), 32'(0));

    repeat (20) apply_stimulus(1'b1);

    send_frame(2, 3, 32'b101, 1'b0, -1);
    apply_stimulus(1'b1);
    send_frame(2, 3, 32'b101, 1'b1, -1);
    apply_stimulus(1'b1);
    send_frame(1, 0, 32'b0, 1'b0, -1);
    send_frame(3, 5, 32'b10011, 1'b0, -1);
    send_frame(0, 4, 32'b0110, 1'b0, -1);
    apply_stimulus(1'b1);
    send_frame(1, 8, 32'b10110101, 1'b0, 3);
    apply_stimulus(1'b1);
    send_frame(1, 6, 32'b110001, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      len = $urandom_range(0, 2 ** LB - 1);
      send_frame($urandom_range(0, NP - 1), len, $urandom, ($urandom_range(0, 3) == 0), -1);
      gap = $urandom_range(0, 2);
      repeat (gap) apply_stimulus(1'b1);
    end

    repeat (4) apply_stimulus(1'b1);
    check_output("data_queue_empty", 32'(data_q.size()), 32'(0));
    check_output("done_queue_empty", 32'(done_q.size()), 32'(0));

    // Wider configuration: 0|111|00011|101|0 must land on serial_out[7] only.
    wide_frame = 13'b0_111_00011_101_0;
    for (int j = 12; j >= 0; j--) begin
      se_in2 = wide_frame[j];
      @(posedge clock);
      #1;
      if (j == 9) check_output("wide_port", 32'(port_number2), 32'(7));
      if (j <= 3 && j >= 1) begin
        check_output("wide_valid", 32'(valid2), 32'(1));
        check_output("wide_serial_out", 32'(serial_out2), 32'(NP2'(wide_frame[j]) << 7));
      end
      if (j == 0) begin
        check_output("wide_done", 32'(done2), 32'(1));
        check_output("wide_parity_err", 32'(parity_err2), 32'(0));
      end
    end
    se_in2 = 1'b1;
    @(posedge clock);
    #1;
    check_output("wide_idle", 32'(serial_out2), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
